ant_reg_arbiter: RTL

Round-robin write arbiter that shares one N-bit load/clear register (42-bit ant-state word by default) among NREQ requesters. It owns the register's load and clear controls and its data input: it selects one requester, latches that requester's data, pulses the register load for exactly one cycle, then acknowledges. A dedicated clear request takes precedence over writes. The block sits between the ant update units and the shared state register.

---
 rtl/ant_reg_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ant_reg_arbiter.sv
// ant_reg_arbiter: round-robin write arbiter in front of the shared ant-state
// register. It grants one requester (or the clear request) at a time, strobes
// the register load or clear for one cycle, then acknowledges the winner.

module ant_reg_arbiter #(
  parameter int N    = 42,
  parameter int NREQ = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NREQ-1:0]     Req,
  input  logic [NREQ*N-1:0]   Wr_Data,
  input  logic                Clr_Req,
  output logic                Reg_Ld,
  output logic                Reg_Clr,
  output logic [N-1:0]        Reg_Data_In,
  output logic [NREQ-1:0]     Grant,
  output logic [NREQ-1:0]     Ack,
  output logic                Clr_Ack,
  output logic                Busy
);

  // A single requester still needs a one-bit index so ptr/sel stay legal vectors
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   sel;
  logic            clr_flag;
  logic [IW-1:0]   pick;
  logic            found;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   scan_idx;
  int              scan_sum;

  // Find the first requester at or after ptr, wrapping past the top index
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_sum = 0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = int'(ptr) + k;
      if (scan_sum >= NREQ) begin
        scan_sum = scan_sum - NREQ;
      end
      scan_idx = IW'(scan_sum);
      if (!found && Req[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  // One-hot form of the chosen requester, loaded into Grant on a write grant
  always_comb begin
    pick_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick_onehot[i] = (pick == IW'(i));
    end
  end

  // State register; reset from any state lands in IDLE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; clear wins over writes, and inputs are ignored outside IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (Clr_Req) begin
          next_state = CLEAR;
        end else if (found) begin
          next_state = LOAD;
        end
      end
      LOAD:    next_state = ACK;
      CLEAR:   next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch winner and its data at the grant, advance ptr after a write ack
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr         <= '0;
      sel         <= '0;
      clr_flag    <= 1'b0;
      Reg_Data_In <= '0;
      Grant       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Clr_Req) begin
            clr_flag <= 1'b1;
          end else if (found) begin
            clr_flag    <= 1'b0;
            sel         <= pick;
            Reg_Data_In <= Wr_Data[pick*N +: N];
            Grant       <= pick_onehot;
          end
        end
        ACK: begin
          Grant <= '0;
          if (!clr_flag) begin
            ptr <= (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode; Reset forces the register clear and masks the load strobe
  always_comb begin
    Reg_Ld  = (state == LOAD) && !Reset;
    Reg_Clr = (state == CLEAR) || Reset;
    Clr_Ack = (state == ACK) && clr_flag;
    Busy    = (state != IDLE);
    Ack     = '0;
    for (int i = 0; i < NREQ; i++) begin
      Ack[i] = (state == ACK) && !clr_flag && (sel == IW'(i));
    end
  end

endmodule
